esc_speed_sched: RTL and testbench

//  Upstream feeder for the four ESC_interface PWM generators. Accepts motor

---
 rtl/esc_speed_sched.sv | 157 +++++++++++++++
 tb/tb_esc_speed_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/esc_speed_sched.sv
// esc_speed_sched: clamps, slew-limits and frame-synchronises four ESC speed commands.
// Optional feature: define SLEW_LIMIT_EN to enable per-frame slew limiting of each output.
`timescale 1ns/1ps
module esc_speed_sched #(
    parameter int          FRAME_CYCLES = 125000,
    parameter logic [10:0] SPD_MAX      = 11'd2000,
    parameter logic [10:0] SLEW_MAX     = 11'd64,
    parameter int          STALE_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld,
    input  logic [10:0] frnt_cmd,
    input  logic [10:0] bck_cmd,
    input  logic [10:0] lft_cmd,
    input  logic [10:0] rght_cmd,
    input  logic        motors_off,
    output logic [10:0] frnt_spd,
    output logic [10:0] bck_spd,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd,
    output logic        wrt,
    output logic        stale
);
    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int SC_W  = $clog2(STALE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [SC_W-1:0]  SC_LIMIT = SC_W'(STALE_FRAMES);

    typedef enum logic [2:0] {S_WAIT, S_UPD0, S_UPD1, S_UPD2, S_UPD3, S_WRT} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [SC_W-1:0]  stale_cnt_q, stale_cnt_d;
    logic             stale_q, wrt_q;
    logic [10:0]      tgt_q  [4];
    logic [10:0]      tgt_d  [4];
    logic [10:0]      work_q [4];
    logic [10:0]      spd_q  [4];
    logic [10:0]      cmd    [4];
    logic [1:0]       sel;
    logic [10:0]      upd_val;
    logic             wrap;
    logic             stale_eff;

    function automatic logic [10:0] clamp_spd(input logic [10:0] c);
        return (c > SPD_MAX) ? SPD_MAX : c;
    endfunction

    // Both operands are bounded by SPD_MAX, so stepping by SLEW_MAX toward the
    // target can neither overshoot SPD_MAX nor wrap below zero.
    function automatic logic [10:0] slew_step(input logic [10:0] cur, input logic [10:0] tgt);
        logic signed [11:0] d;
        logic signed [11:0] lim;
        d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        lim = $signed({1'b0, SLEW_MAX});
        if (d > lim)
            return cur + SLEW_MAX;
        else if (d < -lim)
            return cur - SLEW_MAX;
        else
            return tgt;
    endfunction

    assign wrap      = (frame_cnt_q == CNT_LAST);
    assign stale_eff = stale_q & ~vld;

    always_comb begin
        cmd[0] = frnt_cmd;
        cmd[1] = bck_cmd;
        cmd[2] = lft_cmd;
        cmd[3] = rght_cmd;
        for (int i = 0; i < 4; i++)
            tgt_d[i] = vld ? clamp_spd(cmd[i]) : tgt_q[i];
    end

    always_comb begin
        case (state_q)
            S_UPD1:  sel = 2'd1;
            S_UPD2:  sel = 2'd2;
            S_UPD3:  sel = 2'd3;
            default: sel = 2'd0;
        endcase
`ifdef SLEW_LIMIT_EN
        upd_val = slew_step(spd_q[sel], work_q[sel]);
`else
        upd_val = work_q[sel];
`endif
    end

    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (vld)
            stale_cnt_d = '0;
        else if (state_q == S_WRT && stale_cnt_q < SC_LIMIT)
            stale_cnt_d = stale_cnt_q + SC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT;
            frame_cnt_q <= '0;
            stale_cnt_q <= SC_LIMIT;
            stale_q     <= 1'b1;
            wrt_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tgt_q[i]  <= '0;
                work_q[i] <= '0;
                spd_q[i]  <= '0;
            end
        end else begin
            frame_cnt_q <= wrap ? '0 : frame_cnt_q + CNT_W'(1);
            stale_cnt_q <= stale_cnt_d;
            stale_q     <= (stale_cnt_d >= SC_LIMIT);
            wrt_q       <= 1'b0;
            for (int i = 0; i < 4; i++)
                tgt_q[i] <= tgt_d[i];
            // Snapshot uses this edge's capture so a coincident vld lands in this frame.
            case (state_q)
                S_WAIT: begin
                    if (wrap) begin
                        for (int i = 0; i < 4; i++)
                            work_q[i] <= stale_eff ? 11'd0 : tgt_d[i];
                        state_q <= S_UPD0;
                    end
                end
                S_UPD0: begin
                    spd_q[sel] <= motors_off ? 11'd0 : upd_val;
                    state_q    <= S_UPD1;
                end
                S_UPD1: begin
                    spd_q[sel] <= motors_off ? 11'd0 : upd_val;
                    state_q    <= S_UPD2;
                end
                S_UPD2: begin
                    spd_q[sel] <= motors_off ? 11'd0 : upd_val;
                    state_q    <= S_UPD3;
                end
                S_UPD3: begin
                    spd_q[sel] <= motors_off ? 11'd0 : upd_val;
                    state_q    <= S_WRT;
                    wrt_q      <= 1'b1;
                end
                S_WRT:   state_q <= S_WAIT;
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign frnt_spd = spd_q[0];
    assign bck_spd  = spd_q[1];
    assign lft_spd  = spd_q[2];
    assign rght_spd = spd_q[3];
    assign wrt      = wrt_q;
    assign stale    = stale_q;

endmodule

// File: tb/tb_esc_speed_sched.sv
// Directed bench for esc_speed_sched: frame timing, slew ramps, saturation, kill, stale, reset abort.
`timescale 1ns/1ps
module tb_esc_speed_sched;
`ifdef SLEW_LIMIT_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [10:0] frnt_cmd = '0, bck_cmd = '0, lft_cmd = '0, rght_cmd = '0;
    logic        motors_off = 1'b0;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic        wrt, stale;

    int checks = 0;
    int errors = 0;

    esc_speed_sched #(
        .FRAME_CYCLES(16),
        .SPD_MAX(11'd2000),
        .SLEW_MAX(11'd64),
        .STALE_FRAMES(3)
    ) dut (
        .clk(clk), .rst(rst), .vld(vld),
        .frnt_cmd(frnt_cmd), .bck_cmd(bck_cmd), .lft_cmd(lft_cmd), .rght_cmd(rght_cmd),
        .motors_off(motors_off),
        .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .wrt(wrt), .stale(stale)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [10:0] cf, cb, cl, cr;
        logic        moff;
        logic [10:0] ef, eb, el, er;
        logic        es;
    } vec_t;

    vec_t t2 [6];
    vec_t t4 [11];

    function automatic vec_t mk(input logic v, input int cf, input int cb, input int cl,
                                input int cr, input logic moff, input int ef, input int eb,
                                input int el, input int er, input logic es);
        vec_t m;
        m.v = v; m.cf = 11'(cf); m.cb = 11'(cb); m.cl = 11'(cl); m.cr = 11'(cr);
        m.moff = moff;
        m.ef = 11'(ef); m.eb = 11'(eb); m.el = 11'(el); m.er = 11'(er);
        m.es = es;
        return m;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
        end
    endtask

    task automatic wait_wrt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wrt && n < 64);
        if (!wrt) begin
            checks++;
            errors++;
            $display("FAIL wrt_timeout: got no wrt in %0d cycles expected one", n);
        end
    endtask

    // Called on a wrt cycle: present this frame's inputs, then advance to the next wrt.
    task automatic run_frame(input vec_t r);
        int n;
        vld = r.v; motors_off = r.moff;
        frnt_cmd = r.cf; bck_cmd = r.cb; lft_cmd = r.cl; rght_cmd = r.cr;
        @(negedge clk);
        vld = 1'b0;
        wait_wrt(n);
    endtask

    task automatic check_vec(input string tag, input int k, input vec_t r);
        chk($sformatf("%s[%0d].frnt", tag, k), int'(frnt_spd), int'(r.ef));
        chk($sformatf("%s[%0d].bck",  tag, k), int'(bck_spd),  int'(r.eb));
        chk($sformatf("%s[%0d].lft",  tag, k), int'(lft_spd),  int'(r.el));
        chk($sformatf("%s[%0d].rght", tag, k), int'(rght_spd), int'(r.er));
        chk($sformatf("%s[%0d].stale", tag, k), int'(stale), int'(r.es));
    endtask

    task automatic chk_all(input string nm, input int exp);
        chk({nm, ".frnt"}, int'(frnt_spd), exp);
        chk({nm, ".bck"},  int'(bck_spd),  exp);
        chk({nm, ".lft"},  int'(lft_spd),  exp);
        chk({nm, ".rght"}, int'(rght_spd), exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int mx;
        vec_t sat, mid, p300;

        // single-motor ramp toward 300 on the front output
        t2[0] = mk(1, 300, 0, 0, 0, 0, SLEW ?  64 : 300, 0, 0, 0, 0);
        t2[1] = mk(1, 300, 0, 0, 0, 0, SLEW ? 128 : 300, 0, 0, 0, 0);
        t2[2] = mk(1, 300, 0, 0, 0, 0, SLEW ? 192 : 300, 0, 0, 0, 0);
        t2[3] = mk(1, 300, 0, 0, 0, 0, SLEW ? 256 : 300, 0, 0, 0, 0);
        t2[4] = mk(1, 300, 0, 0, 0, 0, 300, 0, 0, 0, 0);
        t2[5] = mk(1, 300, 0, 0, 0, 0, 300, 0, 0, 0, 0);

        // from 1000 on all outputs: kill, release, retarget to 200, then stale ramp-down
        t4[0]  = mk(1, 1000, 1000, 1000, 1000, 1, 0, 0, 0, 0, 0);
        t4[1]  = mk(0, 0, 0, 0, 0, 0, SLEW ? 64 : 1000, SLEW ? 64 : 1000,
                    SLEW ? 64 : 1000, SLEW ? 64 : 1000, 0);
        t4[2]  = mk(1, 200, 200, 200, 200, 0, SLEW ? 128 : 200, SLEW ? 128 : 200,
                    SLEW ? 128 : 200, SLEW ? 128 : 200, 0);
        t4[3]  = mk(1, 200, 200, 200, 200, 0, SLEW ? 192 : 200, SLEW ? 192 : 200,
                    SLEW ? 192 : 200, SLEW ? 192 : 200, 0);
        t4[4]  = mk(1, 200, 200, 200, 200, 0, 200, 200, 200, 200, 0);
        t4[5]  = mk(0, 0, 0, 0, 0, 0, 200, 200, 200, 200, 0);
        t4[6]  = mk(0, 0, 0, 0, 0, 0, 200, 200, 200, 200, 0);
        t4[7]  = mk(0, 0, 0, 0, 0, 0, SLEW ? 136 : 0, SLEW ? 136 : 0,
                    SLEW ? 136 : 0, SLEW ? 136 : 0, 1);
        t4[8]  = mk(0, 0, 0, 0, 0, 0, SLEW ? 72 : 0, SLEW ? 72 : 0,
                    SLEW ? 72 : 0, SLEW ? 72 : 0, 1);
        t4[9]  = mk(0, 0, 0, 0, 0, 0, SLEW ? 8 : 0, SLEW ? 8 : 0,
                    SLEW ? 8 : 0, SLEW ? 8 : 0, 1);
        t4[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        sat  = mk(1, 2047, 2047, 2047, 2047, 0, 0, 0, 0, 0, 0);
        mid  = mk(1, 1000, 1000, 1000, 1000, 0, 0, 0, 0, 0, 0);
        p300 = mk(1, 300, 300, 300, 300, 0, SLEW ? 64 : 300, SLEW ? 64 : 300,
                  SLEW ? 64 : 300, SLEW ? 64 : 300, 0);

        // reset state and first-frame timing
        repeat (3) @(negedge clk);
        chk_all("reset", 0);
        chk("reset.stale", int'(stale), 1);
        chk("reset.wrt", int'(wrt), 0);
        rst = 1'b0;
        wait_wrt(n);
        chk("first_wrt_cycle", n, 20);
        chk_all("first_wrt", 0);
        chk("first_wrt.stale", int'(stale), 1);
        @(negedge clk);
        chk("wrt_width", int'(wrt), 0);
        wait_wrt(n);
        chk("wrt_period", n + 1, 16);

        for (int k = 0; k < 6; k++) begin
            run_frame(t2[k]);
            check_vec("ramp", k, t2[k]);
        end

        // saturation: commands above SPD_MAX must settle at 2000 and never exceed it
        for (int k = 0; k < 40; k++) begin
            run_frame(sat);
            mx = int'(frnt_spd);
            if (int'(bck_spd)  > mx) mx = int'(bck_spd);
            if (int'(lft_spd)  > mx) mx = int'(lft_spd);
            if (int'(rght_spd) > mx) mx = int'(rght_spd);
            chk_le($sformatf("sat_bound[%0d]", k), mx, 2000);
        end
        chk_all("sat_final", 2000);

        for (int k = 0; k < 20; k++)
            run_frame(mid);
        chk_all("mid_final", 1000);
        chk("mid_final.stale", int'(stale), 0);

        for (int k = 0; k < 11; k++) begin
            run_frame(t4[k]);
            check_vec("kill_stale", k, t4[k]);
        end

        // reset asserted while UPD2 is in progress
        run_frame(p300);
        check_vec("pre_rst", 0, p300);
        repeat (14) @(negedge clk);
        chk("pre_rst_frnt_upd0", int'(frnt_spd), SLEW ? 128 : 300);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0);
        chk("async_rst.stale", int'(stale), 1);
        chk("async_rst.wrt", int'(wrt), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_no_wrt[%0d]", k), int'(wrt), 0);
        end
        rst = 1'b0;
        wait_wrt(n);
        chk("post_rst_wrt_cycle", n, 20);
        chk_all("post_rst_wrt", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
